// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One input bit is consumed per falling edge of NEclk. A start accepted in
// IDLE latches bin. Exactly BITS iterations later the packed BCD digits and
// the overflow flag are published, together with a one-cycle done pulse.
// bcd/ovf only change on a completion, so they never show partial work.
module bin2bcd_seq #(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  NEclk,
    input  logic                  Nreset,
    input  logic                  start,
    input  logic [BITS-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CW = $clog2(BITS + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [BITS-1:0] shift_q;
    logic [SW-1:0]   scratch_q;
    logic            ovf_int_q;
    logic            busy_q;
    logic            done_q;
    logic [SW-1:0]   bcd_q;
    logic            ovf_q;

    logic [SW-1:0]   adj;
    logic [SW-1:0]   scratch_d;
    logic [BITS-1:0] shift_d;
    logic            ovf_int_d;

    // One double-dabble iteration: add-3 correction, then a one-bit left shift.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which is what would otherwise infer a latch.
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        {scratch_d, shift_d} = {adj[SW-2:0], shift_q, 1'b0};
        // The bit pushed out of the top digit means the value no longer fits.
        ovf_int_d = ovf_int_q | adj[SW-1];
    end

    // Control FSM, conversion datapath and registered handshake/result outputs.
    // NOTE: state updates use non-blocking assignments so every register here
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(negedge NEclk or negedge Nreset) begin
        if (!Nreset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_int_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            // done is a single-cycle pulse; it drops on the next edge.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_q   <= bin;
                        scratch_q <= '0;
                        ovf_int_q <= 1'b0;
                        cnt_q     <= CW'(BITS);
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    ovf_int_q <= ovf_int_d;
                    cnt_q     <= cnt_q - CW'(1);
                    // Last iteration: publish the result and return to IDLE,
                    // so a start in the done cycle is accepted.
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= scratch_d;
                        ovf_q   <= ovf_int_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule
